// File: rtl/seq_addsub_ctrl_pkg.sv
// Shared types and default widths for the chunked add/subtract sequencer.
package seq_addsub_ctrl_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_CHUNK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_addsub_ctrl_chunk_rca.sv
// CHUNK_W-bit combinational ripple-carry slice; also exposes the carry into its top bit
// so the caller can form signed overflow.
module seq_addsub_ctrl_chunk_rca #(
  parameter int CHUNK_W = 8
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] s,
  output logic               cout,
  output logic               c_msb_in
);

  logic [CHUNK_W:0] c;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = c[CHUNK_W];
  assign c_msb_in = c[CHUNK_W-1];

endmodule

// File: rtl/seq_addsub_ctrl.sv
// Multi-cycle add/subtract sequencer sweeping one shared ripple-carry slice LSB->MSB.
// Define ABS_DIFF_EN to turn a borrowing subtract into |A-B| via a second negate pass.
module seq_addsub_ctrl
  import seq_addsub_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic              op_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              c_out,
  output logic              ovf
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if (DATA_W % CHUNK_W != 0) begin : g_bad_width
    $error("seq_addsub_ctrl: DATA_W must be a multiple of CHUNK_W");
  end

  state_e            state;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              carry;
  logic [IDX_W-1:0]  idx;
`ifdef ABS_DIFF_EN
  logic              op_sub_q;
`endif

  logic [CHUNK_W-1:0] slice_a;
  logic [CHUNK_W-1:0] slice_b;
  logic [CHUNK_W-1:0] slice_s;
  logic               slice_cout;
  logic               slice_c_msb;
  logic [DATA_W-1:0]  sum_next;

  always_comb begin
    slice_a = op_a[int'(idx)*CHUNK_W +: CHUNK_W];
    slice_b = op_b[int'(idx)*CHUNK_W +: CHUNK_W];
    sum_next = sum;
    sum_next[int'(idx)*CHUNK_W +: CHUNK_W] = slice_s;
  end

  seq_addsub_ctrl_chunk_rca #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk_rca (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      idx       <= '0;
`ifdef ABS_DIFF_EN
      op_sub_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= in1;
            op_b     <= op_sub ? ~in2 : in2;
            carry    <= op_sub;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
`ifdef ABS_DIFF_EN
            op_sub_q <= op_sub;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end

        ST_RUN: begin
          sum   <= sum_next;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            idx <= '0;
`ifdef ABS_DIFF_EN
            // A borrow means the raw result is negative: negate it as ~sum + 1.
            if (op_sub_q && !slice_cout) begin
              op_a  <= ~sum_next;
              op_b  <= '0;
              carry <= 1'b1;
              state <= ST_NEG;
            end else begin
              c_out <= slice_cout;
              ovf   <= slice_c_msb ^ slice_cout;
              state <= ST_DONE;
            end
`else
            c_out <= slice_cout;
            ovf   <= slice_c_msb ^ slice_cout;
            state <= ST_DONE;
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end

`ifdef ABS_DIFF_EN
        ST_NEG: begin
          sum   <= sum_next;
          carry <= slice_cout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`endif

        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub_ctrl.sv
// Randomized self-checking bench for seq_addsub_ctrl against a plain-arithmetic reference.
module tb_seq_addsub_ctrl;

  localparam int DATA_W  = 64;
  localparam int CHUNK_W = 8;
  localparam int NCHUNK  = DATA_W / CHUNK_W;
  localparam int MAX_LAT = 40;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic              op_sub;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] sum;
  logic              c_out;
  logic              ovf;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] last_sum;
  logic              last_c;
  logic              last_ovf;

  seq_addsub_ctrl #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: straight modular arithmetic on the full operands.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       output logic [63:0] s, output logic c, output logic v, output int lat);
    logic [64:0] full;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b};
      c    = ~full[64];
      s    = full[63:0];
      v    = (a[63] != b[63]) && (s[63] != a[63]);
    end else begin
      full = {1'b0, a} + {1'b0, b};
      c    = full[64];
      s    = full[63:0];
      v    = (a[63] == b[63]) && (s[63] != a[63]);
    end
    lat = NCHUNK + 1;
`ifdef ABS_DIFF_EN
    if (sub && !c) begin
      s   = b - a;
      c   = 1'b0;
      v   = 1'b0;
      lat = 2 * NCHUNK + 1;
    end
`endif
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        input int hold, input logic pre_ready);
    logic [63:0] e_sum;
    logic        e_c;
    logic        e_v;
    int          e_lat;
    int          lat;
    int          w;
    model(a, b, sub, e_sum, e_c, e_v, e_lat);

    @(negedge clk);
    w = 0;
    while (!in_ready && w < MAX_LAT) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in1       = a;
    in2       = b;
    op_sub    = sub;
    in_valid  = 1'b1;
    out_ready = pre_ready;
    @(posedge clk);
    #1;
    check("in_ready_busy", 64'(in_ready), 64'd0);

    // Scribble on the inputs while the operation is in flight.
    @(negedge clk);
    in_valid = 1'($urandom);
    in1      = {$urandom(), $urandom()};
    in2      = {$urandom(), $urandom()};
    op_sub   = 1'($urandom);

    lat = 1;
    @(posedge clk);
    #1;
    while (!out_valid && lat < MAX_LAT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(e_lat));
    check("sum", sum, e_sum);
    check("c_out", 64'(c_out), 64'(e_c));
    check("ovf", 64'(ovf), 64'(e_v));
    check("in_ready_done", 64'(in_ready), 64'd0);
    last_sum = sum;
    last_c   = c_out;
    last_ovf = ovf;

    if (pre_ready) begin
      @(posedge clk);
      #1;
      check("single_cycle_valid", 64'(out_valid), 64'd0);
      check("ready_after_done", 64'(in_ready), 64'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid = 1'($urandom);
        in1      = {$urandom(), $urandom()};
        @(posedge clk);
        #1;
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_sum", sum, e_sum);
        check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("valid_cleared", 64'(out_valid), 64'd0);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int          w;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    op_sub    = 1'b0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_c_out", 64'(c_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    run_op(64'd98345672198765, 64'd12765438912345, 1'b0, 0, 1'b0);
    check("dir_add_const", last_sum, 64'd111111111111110);
    run_op(64'd98345672198765, 64'd12765438912345, 1'b1, 1, 1'b0);
    check("dir_sub_const", last_sum, 64'd85580233286420);
    check("dir_sub_c", 64'(last_c), 64'd1);
    run_op(64'd12345432198765, 64'd98765678912345, 1'b1, 0, 1'b0);
`ifdef ABS_DIFF_EN
    check("dir_abs_const", last_sum, 64'd86420246713580);
`else
    check("dir_neg_const", last_sum, 64'd18446657653462838036);
`endif
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b1);
    check("dir_wrap_c", 64'(last_c), 64'd1);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, 1'b0);
    check("dir_ovf", 64'(last_ovf), 64'd1);
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 0, 1'b1);
    run_op(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b0, 10, 1'b0);

    // Asynchronous reset part-way through RUN abandons the operation.
    @(negedge clk);
    w = 0;
    while (!in_ready && w < MAX_LAT) begin
      @(negedge clk);
      w++;
    end
    in1      = 64'h1111_1111_1111_1111;
    in2      = 64'h1111_1111_1111_1111;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_partial", 64'(sum != 64'd0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", sum, 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_c_out", 64'(c_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready_back", 64'(in_ready), 64'd1);
    run_op(64'd98345672198765, 64'd12765438912345, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      case ($urandom_range(0, 3))
        1: rb = ra;
        2: rb = ra + 64'd1;
        3: begin
          ra[63] = 1'b0;
          rb[63] = 1'b0;
          ra[62] = 1'b1;
          rb[62] = 1'b1;
        end
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
